// File: rtl/half_duplex_spi_slave.sv
// Half-duplex (3-wire) SPI responder. Oversamples SCLK/CS_n/SDIO in the
// fabric_clk domain, decodes {rw, addr, data} frames (MSB first) and turns
// each complete frame into one register-port write or read.
module half_duplex_spi_slave #(
   parameter int ADDR_WIDTH  = 7,
   parameter int DATA_WIDTH  = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  fabric_clk,
   input  logic                  reset_n,
   input  logic                  spi_cpol,
   input  logic                  spi_cpha,
   input  logic                  spi_sclk,
   input  logic                  spi_cs_n,
   input  logic                  spi_sdio_in,
   output logic                  spi_sdio_out,
   output logic                  spi_sdio_oe,
   output logic [ADDR_WIDTH-1:0] reg_addr,
   output logic [DATA_WIDTH-1:0] reg_wdata,
   output logic                  reg_wr_en,
   output logic                  reg_rd_en,
   input  logic [DATA_WIDTH-1:0] reg_rdata,
   output logic                  busy,
   output logic                  frame_error
);

   localparam int CMD_BITS   = 1 + ADDR_WIDTH;
   localparam int FRAME_BITS = CMD_BITS + DATA_WIDTH;
   localparam int CNT_W      = $clog2(FRAME_BITS + 1);
   localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(CMD_BITS - 1);
   localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_BITS - 1);
   localparam logic [CNT_W-1:0] FRAME_FULL = CNT_W'(FRAME_BITS);

   typedef enum logic [2:0] {IDLE, CMD, WRITE, FETCH, READ, DONE} state_t;

   // ---------------------------------------------------------------
   // Pin synchronizers: each generate stage owns its own flops
   // ---------------------------------------------------------------
   for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      logic sclk_q;
      logic cs_q;
      logic sdio_q;
      logic sclk_src;
      logic cs_src;
      logic sdio_src;

      if (gi == 0) begin : g_first
         assign sclk_src = spi_sclk;
         assign cs_src   = spi_cs_n;
         assign sdio_src = spi_sdio_in;
      end else begin : g_rest
         assign sclk_src = g_sync[gi-1].sclk_q;
         assign cs_src   = g_sync[gi-1].cs_q;
         assign sdio_src = g_sync[gi-1].sdio_q;
      end

      // One synchronizer stage; idle levels are the reset values so no false edges
      always_ff @(posedge fabric_clk or negedge reset_n) begin
         if (!reset_n) begin
            sclk_q <= spi_cpol;
            cs_q   <= 1'b1;
            sdio_q <= 1'b0;
         end else begin
            sclk_q <= sclk_src;
            cs_q   <= cs_src;
            sdio_q <= sdio_src;
         end
      end
   end

   logic sclk_s;
   logic cs_s;
   logic sdio_s;
   logic sclk_prev;

   assign sclk_s = g_sync[SYNC_STAGES-1].sclk_q;
   assign cs_s   = g_sync[SYNC_STAGES-1].cs_q;
   assign sdio_s = g_sync[SYNC_STAGES-1].sdio_q;

   // Delayed copy of synced SCLK for edge detection
   always_ff @(posedge fabric_clk or negedge reset_n) begin
      if (!reset_n) sclk_prev <= spi_cpol;
      else          sclk_prev <= sclk_s;
   end

   // Leading edge leaves the CPOL idle level, trailing edge returns to it
   logic leading_edge;
   logic trailing_edge;
   logic sample_edge;
   logic shift_edge;

   assign leading_edge  = (sclk_prev == spi_cpol) && (sclk_s != spi_cpol);
   assign trailing_edge = (sclk_prev != spi_cpol) && (sclk_s == spi_cpol);
   assign sample_edge   = spi_cpha ? trailing_edge : leading_edge;
   assign shift_edge    = spi_cpha ? leading_edge  : trailing_edge;

   // ---------------------------------------------------------------
   // Frame state and datapath registers
   // ---------------------------------------------------------------
   state_t                state_reg,       state_next;
   logic [CNT_W-1:0]      cnt_reg,         cnt_next;
   logic [CMD_BITS-1:0]   cmd_reg,         cmd_next;
   logic [DATA_WIDTH-1:0] wr_shift_reg,    wr_shift_next;
   logic [DATA_WIDTH-1:0] rd_shift_reg,    rd_shift_next;
   logic                  sdio_out_reg,    sdio_out_next;
   logic                  oe_reg,          oe_next;
   logic [ADDR_WIDTH-1:0] addr_reg,        addr_next;
   logic [DATA_WIDTH-1:0] wdata_reg,       wdata_next;
   logic                  wr_en_reg,       wr_en_next;
   logic                  rd_en_reg,       rd_en_next;
   logic                  frame_error_reg, frame_error_next;

   logic [CMD_BITS-1:0]   cmd_shifted;
   logic [DATA_WIDTH-1:0] wr_shifted;

   assign cmd_shifted = {cmd_reg[CMD_BITS-2:0], sdio_s};
   assign wr_shifted  = {wr_shift_reg[DATA_WIDTH-2:0], sdio_s};

   // State and datapath register update; async reset drops oe and strobes at once
   always_ff @(posedge fabric_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg       <= IDLE;
         cnt_reg         <= '0;
         cmd_reg         <= '0;
         wr_shift_reg    <= '0;
         rd_shift_reg    <= '0;
         sdio_out_reg    <= 1'b0;
         oe_reg          <= 1'b0;
         addr_reg        <= '0;
         wdata_reg       <= '0;
         wr_en_reg       <= 1'b0;
         rd_en_reg       <= 1'b0;
         frame_error_reg <= 1'b0;
      end else begin
         state_reg       <= state_next;
         cnt_reg         <= cnt_next;
         cmd_reg         <= cmd_next;
         wr_shift_reg    <= wr_shift_next;
         rd_shift_reg    <= rd_shift_next;
         sdio_out_reg    <= sdio_out_next;
         oe_reg          <= oe_next;
         addr_reg        <= addr_next;
         wdata_reg       <= wdata_next;
         wr_en_reg       <= wr_en_next;
         rd_en_reg       <= rd_en_next;
         frame_error_reg <= frame_error_next;
      end
   end

   // Next-state and output decode for the frame sequencer
   always_comb begin
      state_next       = state_reg;
      cnt_next         = cnt_reg;
      cmd_next         = cmd_reg;
      wr_shift_next    = wr_shift_reg;
      rd_shift_next    = rd_shift_reg;
      sdio_out_next    = sdio_out_reg;
      oe_next          = oe_reg;
      addr_next        = addr_reg;
      wdata_next       = wdata_reg;
      wr_en_next       = 1'b0;
      rd_en_next       = 1'b0;
      frame_error_next = 1'b0;

      case (state_reg)
         IDLE: begin
            oe_next       = 1'b0;
            sdio_out_next = 1'b0;
            if (!cs_s) begin
               state_next = CMD;
               cnt_next   = '0;
            end
         end
         CMD: begin
            if (sample_edge) begin
               cmd_next = cmd_shifted;
               cnt_next = cnt_reg + 1'b1;
               if (cnt_reg == CMD_LAST) begin
                  if (cmd_shifted[ADDR_WIDTH]) begin
                     state_next = FETCH;
                     rd_en_next = 1'b1;
                     addr_next  = cmd_shifted[ADDR_WIDTH-1:0];
                  end else begin
                     state_next = WRITE;
                  end
               end
            end
         end
         WRITE: begin
            if (sample_edge) begin
               wr_shift_next = wr_shifted;
               cnt_next      = cnt_reg + 1'b1;
               if (cnt_reg == FRAME_LAST) begin
                  wr_en_next = 1'b1;
                  addr_next  = cmd_reg[ADDR_WIDTH-1:0];
                  wdata_next = wr_shifted;
                  state_next = DONE;
               end
            end
         end
         FETCH: begin
            // The strobe cycle is spent waiting; read data is valid the cycle after it
            if (!rd_en_reg) begin
               rd_shift_next = reg_rdata;
               state_next    = READ;
            end
         end
         READ: begin
            if (sample_edge) begin
               cnt_next = cnt_reg + 1'b1;
            end
            if (shift_edge) begin
               if (cnt_reg == FRAME_FULL) begin
                  oe_next    = 1'b0;
                  state_next = DONE;
               end else begin
                  sdio_out_next = rd_shift_reg[DATA_WIDTH-1];
                  rd_shift_next = {rd_shift_reg[DATA_WIDTH-2:0], 1'b0};
                  oe_next       = 1'b1;
               end
            end
         end
         DONE: begin
            oe_next = 1'b0;
         end
         default: begin
            state_next = IDLE;
            oe_next    = 1'b0;
         end
      endcase

      // CS_n release ends any frame; a final sample in the same cycle still completes it
      if ((state_reg != IDLE) && cs_s) begin
         state_next       = IDLE;
         oe_next          = 1'b0;
         rd_en_next       = 1'b0;
         frame_error_next = (cnt_next != FRAME_FULL);
      end
   end

   assign spi_sdio_out = sdio_out_reg;
   assign spi_sdio_oe  = oe_reg;
   assign reg_addr     = addr_reg;
   assign reg_wdata    = wdata_reg;
   assign reg_wr_en    = wr_en_reg;
   assign reg_rd_en    = rd_en_reg;
   assign frame_error  = frame_error_reg;
   assign busy         = (state_reg != IDLE);

endmodule

// File: tb/tb_half_duplex_spi_slave.sv
// Bench for half_duplex_spi_slave: a behavioural SPI master drives frames in
// all four modes; a register-file model answers the register port and a
// transaction-level memory model predicts every write and read result.
module tb_half_duplex_spi_slave;

   logic        fabric_clk;
   logic        reset_n;
   logic        spi_cpol;
   logic        spi_cpha;
   logic        spi_sclk;
   logic        spi_cs_n;
   logic        spi_sdio_in;
   logic        spi_sdio_out;
   logic        spi_sdio_oe;
   logic [6:0]  reg_addr;
   logic [15:0] reg_wdata;
   logic        reg_wr_en;
   logic        reg_rd_en;
   logic [15:0] reg_rdata;
   logic        busy;
   logic        frame_error;

   half_duplex_spi_slave #(
      .ADDR_WIDTH  (7),
      .DATA_WIDTH  (16),
      .SYNC_STAGES (2)
   ) dut (
      .fabric_clk   (fabric_clk),
      .reset_n      (reset_n),
      .spi_cpol     (spi_cpol),
      .spi_cpha     (spi_cpha),
      .spi_sclk     (spi_sclk),
      .spi_cs_n     (spi_cs_n),
      .spi_sdio_in  (spi_sdio_in),
      .spi_sdio_out (spi_sdio_out),
      .spi_sdio_oe  (spi_sdio_oe),
      .reg_addr     (reg_addr),
      .reg_wdata    (reg_wdata),
      .reg_wr_en    (reg_wr_en),
      .reg_rd_en    (reg_rd_en),
      .reg_rdata    (reg_rdata),
      .busy         (busy),
      .frame_error  (frame_error)
   );

   initial begin
      fabric_clk = 1'b0;
      forever #5 fabric_clk = ~fabric_clk;
   end

   // Register file attached to the register port (1-cycle read latency)
   logic [15:0] regfile [128];
   always @(posedge fabric_clk) begin
      if (reg_wr_en) regfile[reg_addr] <= reg_wdata;
      if (reg_rd_en) reg_rdata <= regfile[reg_addr];
   end

   // Strobe / pulse monitors, sampled away from the active edge
   logic [22:0] wr_log [$];
   logic [6:0]  rd_log [$];
   int          fe_count;
   int          oe_cycles;
   initial begin
      fe_count  = 0;
      oe_cycles = 0;
   end
   always @(negedge fabric_clk) begin
      if (reg_wr_en)   wr_log.push_back({reg_addr, reg_wdata});
      if (reg_rd_en)   rd_log.push_back(reg_addr);
      if (frame_error) fe_count++;
      if (spi_sdio_oe) oe_cycles++;
   end

   // Transaction-level reference: what each address should hold
   logic [15:0] model_mem [128];
   logic [6:0]  written [$];

   int n_vec;
   int n_err;
   int txn_no;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endfunction

   task automatic half_period();
      repeat (4) @(negedge fabric_clk);
   endtask

   task automatic settle();
      repeat (8) @(negedge fabric_clk);
   endtask

   // One master frame. nbits < 24 aborts early; reset_bit >= 0 asserts reset_n at that bit.
   task automatic spi_frame(input bit cpol, input bit cpha, input bit rw,
                            input logic [6:0] addr, input logic [15:0] wdata,
                            input int nbits, input int pre_gap, input int reset_bit,
                            output logic [15:0] rdata);
      logic [23:0] frame;
      int          oe_bad;
      bit          is_rd_bit;
      frame  = {rw, addr, wdata};
      rdata  = '0;
      oe_bad = 0;
      spi_cpol = cpol;
      spi_cpha = cpha;
      spi_sclk = cpol;
      repeat (pre_gap) @(negedge fabric_clk);
      spi_cs_n = 1'b0;
      for (int b = 0; b < nbits; b++) begin
         is_rd_bit = rw && (b >= 8);
         if (b == reset_bit) begin
            check("oe_before_reset", {31'd0, spi_sdio_oe}, 32'd1);
            reset_n = 1'b0;
            #1;
            check("oe_at_reset", {31'd0, spi_sdio_oe}, 32'd0);
            check("strobes_at_reset", {30'd0, reg_wr_en, reg_rd_en}, 32'd0);
            spi_cs_n = 1'b1;
            spi_sclk = cpol;
            repeat (2) @(negedge fabric_clk);
            reset_n = 1'b1;
            return;
         end
         if (!cpha) begin
            spi_sdio_in = is_rd_bit ? 1'($urandom) : frame[23-b];
            half_period();
            if (is_rd_bit) begin
               rdata = {rdata[14:0], spi_sdio_out};
               if (!spi_sdio_oe) oe_bad++;
            end
            spi_sclk = ~cpol;
            half_period();
            spi_sclk = cpol;
         end else begin
            half_period();
            spi_sclk    = ~cpol;
            spi_sdio_in = is_rd_bit ? 1'($urandom) : frame[23-b];
            half_period();
            if (is_rd_bit) begin
               rdata = {rdata[14:0], spi_sdio_out};
               if (!spi_sdio_oe) oe_bad++;
            end
            spi_sclk = cpol;
         end
      end
      half_period();
      if (rw && nbits == 24) begin
         check("oe_during_read_data", oe_bad, 0);
         if (!cpha) check("oe_off_after_last_shift", {31'd0, spi_sdio_oe}, 32'd0);
      end
      spi_cs_n = 1'b1;
   endtask

   // Full frame plus all per-transaction expectations
   task automatic do_txn(input bit cpol, input bit cpha, input bit rw,
                         input logic [6:0] addr, input logic [15:0] data, input string tag);
      int          wr0, rd0, fe0, oe0;
      logic [15:0] got;
      wr0 = wr_log.size();
      rd0 = rd_log.size();
      fe0 = fe_count;
      oe0 = oe_cycles;
      spi_frame(cpol, cpha, rw, addr, data, 24, 8, -1, got);
      settle();
      if (rw) begin
         check({tag, "_rd_strobes"}, rd_log.size() - rd0, 1);
         check({tag, "_rd_addr"}, {25'd0, rd_log[rd_log.size()-1]}, {25'd0, addr});
         check({tag, "_rd_data"}, {16'd0, got}, {16'd0, data});
         check({tag, "_oe_after"}, {31'd0, spi_sdio_oe}, 32'd0);
         check({tag, "_no_wr"}, wr_log.size() - wr0, 0);
      end else begin
         check({tag, "_wr_strobes"}, wr_log.size() - wr0, 1);
         check({tag, "_wr_addr_data"}, {9'd0, wr_log[wr_log.size()-1]}, {9'd0, addr, data});
         check({tag, "_oe_never"}, oe_cycles - oe0, 0);
         model_mem[addr] = data;
         written.push_back(addr);
      end
      check({tag, "_no_frame_error"}, fe_count - fe0, 0);
      check({tag, "_idle_after"}, {31'd0, busy}, 32'd0);
      txn_no++;
      $display("txn %0d %s mode %0d %s addr 0x%02h data 0x%04h", txn_no, tag,
               {cpol, cpha}, rw ? "read " : "write", addr, rw ? got : data);
   endtask

   typedef struct {
      bit          cpol;
      bit          cpha;
      bit          rw;
      logic [6:0]  addr;
      logic [15:0] data;   // write data, or expected read data
   } vec_t;

   vec_t vecs [6];

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      logic [15:0] dummy;
      int          wr0, fe0;
      n_vec  = 0;
      n_err  = 0;
      txn_no = 0;

      vecs[0] = '{cpol: 1'b0, cpha: 1'b0, rw: 1'b0, addr: 7'h15, data: 16'hBEEF};
      vecs[1] = '{cpol: 1'b0, cpha: 1'b1, rw: 1'b0, addr: 7'h2A, data: 16'h1234};
      vecs[2] = '{cpol: 1'b1, cpha: 1'b1, rw: 1'b1, addr: 7'h2A, data: 16'h1234};
      vecs[3] = '{cpol: 1'b1, cpha: 1'b0, rw: 1'b1, addr: 7'h15, data: 16'hBEEF};
      vecs[4] = '{cpol: 1'b1, cpha: 1'b0, rw: 1'b0, addr: 7'h7F, data: 16'h8001};
      vecs[5] = '{cpol: 1'b0, cpha: 1'b0, rw: 1'b1, addr: 7'h7F, data: 16'h8001};

      reset_n     = 1'b0;
      spi_cpol    = 1'b0;
      spi_cpha    = 1'b0;
      spi_sclk    = 1'b0;
      spi_cs_n    = 1'b1;
      spi_sdio_in = 1'b0;
      repeat (4) @(negedge fabric_clk);

      check("reset_oe", {31'd0, spi_sdio_oe}, 32'd0);
      check("reset_sdio_out", {31'd0, spi_sdio_out}, 32'd0);
      check("reset_strobes", {30'd0, reg_wr_en, reg_rd_en}, 32'd0);
      check("reset_busy_err", {30'd0, busy, frame_error}, 32'd0);
      check("reset_addr_wdata", {9'd0, reg_addr, reg_wdata}, 32'd0);
      reset_n = 1'b1;
      settle();

      // Directed table: the named write/read cases across modes
      for (int i = 0; i < 6; i++) begin
         do_txn(vecs[i].cpol, vecs[i].cpha, vecs[i].rw, vecs[i].addr, vecs[i].data,
                $sformatf("vec%0d", i));
      end

      // CS_n released after 10 write bits
      wr0 = wr_log.size();
      fe0 = fe_count;
      spi_frame(1'b0, 1'b0, 1'b0, 7'h33, 16'hA5A5, 10, 8, -1, dummy);
      settle();
      check("abort_frame_error_pulses", fe_count - fe0, 1);
      check("abort_no_write", wr_log.size() - wr0, 0);
      check("abort_idle", {31'd0, busy}, 32'd0);
      txn_no++;
      $display("txn %0d aborted write after 10 bits", txn_no);

      // Back-to-back writes with CS_n high for only 4 cycles between them
      wr0 = wr_log.size();
      spi_frame(1'b1, 1'b1, 1'b0, 7'h01, 16'h1111, 24, 4, -1, dummy);
      spi_frame(1'b1, 1'b1, 1'b0, 7'h02, 16'h2222, 24, 4, -1, dummy);
      settle();
      check("b2b_wr_count", wr_log.size() - wr0, 2);
      check("b2b_first", {9'd0, wr_log[wr0]}, {9'd0, 7'h01, 16'h1111});
      check("b2b_second", {9'd0, wr_log[wr0+1]}, {9'd0, 7'h02, 16'h2222});
      model_mem[7'h01] = 16'h1111;
      model_mem[7'h02] = 16'h2222;
      written.push_back(7'h01);
      written.push_back(7'h02);
      txn_no++;
      $display("txn %0d back-to-back writes 0x01/0x02", txn_no);

      // Reset during read data bit 5, then a normal frame
      fe0 = fe_count;
      spi_frame(1'b0, 1'b0, 1'b1, 7'h15, 16'h0000, 24, 8, 13, dummy);
      settle();
      check("post_reset_idle", {31'd0, busy}, 32'd0);
      check("post_reset_no_error", fe_count - fe0, 0);
      txn_no++;
      $display("txn %0d read interrupted by reset", txn_no);
      do_txn(1'b0, 1'b0, 1'b1, 7'h2A, model_mem[7'h2A], "after_reset");

      // Randomized frames against the memory model
      for (int i = 0; i < 40; i++) begin
         bit          cpol, cpha, rw;
         logic [6:0]  addr;
         logic [15:0] data;
         cpol = 1'($urandom);
         cpha = 1'($urandom);
         rw   = 1'($urandom);
         if (rw) begin
            addr = written[$urandom_range(0, written.size() - 1)];
            data = model_mem[addr];
         end else begin
            addr = 7'($urandom);
            data = 16'($urandom);
         end
         do_txn(cpol, cpha, rw, addr, data, $sformatf("rnd%0d", i));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
